// File: rtl/eth_rx_failover_mux_if.sv
// rtl/eth_rx_failover_mux_if.sv - Ethernet RX frame stream bundle, LANES parallel ports
interface eth_rx_if #(
  parameter int LANES  = 1,
  parameter int DATA_W = 8
);
  logic [LANES-1:0][DATA_W-1:0] data;
  logic [LANES-1:0]             data_valid;
  logic [LANES-1:0]             start;
  logic [LANES-1:0]             commit;
  logic [LANES-1:0]             drop;

  modport master (output data, data_valid, start, commit, drop);
  modport slave  (input  data, data_valid, start, commit, drop);
endinterface

// File: rtl/eth_rx_failover_mux.sv
// rtl/eth_rx_failover_mux.sv - priority failover mux for Ethernet RX frame streams
module eth_rx_failover_mux #(
  parameter int NUM_PORTS      = 2,
  parameter int HOLDOFF_CYCLES = 250000,
  parameter int CNT_WIDTH      = 16,
  parameter int DATA_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PORTS-1:0]  port_link_up,
  eth_rx_if.slave               port_rx_bus,
  output logic                  eth_link_up,
  eth_rx_if.master              eth_rx_bus,
  output logic                  active_valid,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] active_port,
  output logic [CNT_WIDTH-1:0]  switch_count,
  output logic [CNT_WIDTH-1:0]  abort_count
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF_CYCLES);

  localparam logic [1:0] S_NO_OWNER   = 2'd0;
  localparam logic [1:0] S_WAIT_START = 2'd1;
  localparam logic [1:0] S_IN_FRAME   = 2'd2;
  localparam logic [1:0] S_IDLE_GAP   = 2'd3;

  logic [HW-1:0]        hold_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] qual;
  logic                 any_qual;
  logic [PW-1:0]        best;

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic                 sw_inc, ab_inc;
  logic [CNT_WIDTH-1:0] sw_q, ab_q;
  logic                 link_q;

  logic                 start_q, start_d, dv_q, dv_d, commit_q, commit_d, drop_q, drop_d;
  logic [DATA_W-1:0]    data_q, data_d;

  logic                 own_start, own_dv, own_commit, own_drop, own_end, reselect;
  logic [DATA_W-1:0]    own_data;

  // Hold-off counters: count continuous link-up, clear the instant a link drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!port_link_up[i])          hold_q[i] <= '0;
        else if (hold_q[i] != HOLD_MAX) hold_q[i] <= hold_q[i] + 1'b1;
      end
    end
  end

  // Qualification and lowest-index qualified port
  always_comb begin
    qual = '0;
    best = '0;
    for (int i = 0; i < NUM_PORTS; i++) qual[i] = port_link_up[i] && (hold_q[i] == HOLD_MAX);
    for (int i = NUM_PORTS - 1; i >= 0; i--) if (qual[i]) best = PW'(i);
    any_qual = |qual;
  end

  assign own_start  = port_rx_bus.start[owner_q];
  assign own_dv     = port_rx_bus.data_valid[owner_q];
  assign own_commit = port_rx_bus.commit[owner_q];
  assign own_drop   = port_rx_bus.drop[owner_q];
  assign own_data   = port_rx_bus.data[owner_q];
  assign own_end    = own_commit || own_drop;
  assign reselect   = !qual[owner_q] || (best != owner_q);

  // Ownership state machine and next output word
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    sw_inc   = 1'b0;
    ab_inc   = 1'b0;
    start_d  = 1'b0;
    dv_d     = 1'b0;
    commit_d = 1'b0;
    drop_d   = 1'b0;
    data_d   = '0;
    case (state_q)
      S_NO_OWNER: begin
        if (any_qual) begin
          owner_d = best;
          sw_inc  = 1'b1;
          state_d = S_WAIT_START;
        end
      end
      S_WAIT_START, S_IDLE_GAP: begin
        if (reselect) begin
          // Any start seen this cycle is discarded; no frame is open so no drop
          if (any_qual) begin
            owner_d = best;
            sw_inc  = 1'b1;
            state_d = S_WAIT_START;
          end else begin
            state_d = S_NO_OWNER;
          end
        end else if (state_q == S_IDLE_GAP || own_start) begin
          start_d  = own_start;
          dv_d     = own_dv;
          commit_d = own_commit;
          drop_d   = own_drop;
          data_d   = own_data;
          if (own_start) state_d = own_end ? S_IDLE_GAP : S_IN_FRAME;
        end
      end
      default: begin
        if (!qual[owner_q]) begin
          drop_d  = 1'b1;
          ab_inc  = 1'b1;
          state_d = S_NO_OWNER;
        end else begin
          start_d  = own_start;
          dv_d     = own_dv;
          commit_d = own_commit;
          drop_d   = own_drop;
          data_d   = own_data;
          if (own_end) state_d = S_IDLE_GAP;
        end
      end
    endcase
  end

  // State, owner, saturating statistics and registered output word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_NO_OWNER;
      owner_q  <= '0;
      sw_q     <= '0;
      ab_q     <= '0;
      link_q   <= 1'b0;
      start_q  <= 1'b0;
      dv_q     <= 1'b0;
      commit_q <= 1'b0;
      drop_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      link_q   <= any_qual;
      start_q  <= start_d;
      dv_q     <= dv_d;
      commit_q <= commit_d;
      drop_q   <= drop_d;
      data_q   <= data_d;
      if (sw_inc && sw_q != '1) sw_q <= sw_q + 1'b1;
      if (ab_inc && ab_q != '1) ab_q <= ab_q + 1'b1;
    end
  end

  assign eth_link_up              = link_q;
  assign active_valid             = (state_q != S_NO_OWNER);
  assign active_port              = owner_q;
  assign switch_count             = sw_q;
  assign abort_count              = ab_q;
  assign eth_rx_bus.start[0]      = start_q;
  assign eth_rx_bus.data_valid[0] = dv_q;
  assign eth_rx_bus.commit[0]     = commit_q;
  assign eth_rx_bus.drop[0]       = drop_q;
  assign eth_rx_bus.data[0]       = data_q;
endmodule

// File: tb/tb_eth_rx_failover_mux.sv
// tb/tb_eth_rx_failover_mux.sv - self-checking bench for eth_rx_failover_mux
module tb_eth_rx_failover_mux;
  localparam int NP = 3;
  localparam int HOLD = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0] link = '0;
  logic eth_link_up, active_valid;
  logic [1:0] active_port;
  logic [CW-1:0] switch_count, abort_count;

  eth_rx_if #(.LANES(NP), .DATA_W(8)) in_bus ();
  eth_rx_if #(.LANES(1),  .DATA_W(8)) out_bus ();

  eth_rx_failover_mux #(.NUM_PORTS(NP), .HOLDOFF_CYCLES(HOLD), .CNT_WIDTH(CW), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .port_link_up(link), .port_rx_bus(in_bus.slave),
    .eth_link_up(eth_link_up), .eth_rx_bus(out_bus.master), .active_valid(active_valid),
    .active_port(active_port), .switch_count(switch_count), .abort_count(abort_count));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-port up streak, owner, and whether a frame start is awaited / a frame is open
  int m_streak [NP];
  bit m_has = 0, m_wait = 0, m_open = 0, m_link = 0;
  int m_owner = 0, m_sw = 0, m_ab = 0;
  logic [11:0] m_out = '0;  // {start, dv, commit, drop, data}

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) m_streak[i] = 0;
      m_has = 0; m_wait = 0; m_open = 0; m_link = 0;
      m_owner = 0; m_sw = 0; m_ab = 0; m_out = '0;
    end else begin
      bit q [NP];
      int best;
      logic [11:0] ob;
      best = -1;
      for (int i = 0; i < NP; i++) begin
        q[i] = link[i] && (m_streak[i] >= HOLD);
        if (q[i] && best < 0) best = i;
      end
      ob = {in_bus.start[m_owner], in_bus.data_valid[m_owner], in_bus.commit[m_owner],
            in_bus.drop[m_owner], in_bus.data[m_owner]};
      m_out = '0;
      if (!m_has) begin
        if (best >= 0) begin m_has = 1; m_owner = best; m_wait = 1; m_sw++; end
      end else if (m_open) begin
        if (!q[m_owner]) begin
          m_out = 12'h100; m_ab++; m_has = 0; m_open = 0;
        end else begin
          m_out = ob;
          if (ob[9] || ob[8]) m_open = 0;
        end
      end else if (best != m_owner) begin
        if (best < 0) m_has = 0;
        else begin m_owner = best; m_wait = 1; m_sw++; end
      end else if (m_wait) begin
        if (ob[11]) begin
          m_out = ob; m_wait = 0;
          m_open = !(ob[9] || ob[8]);
        end
      end else begin
        m_out = ob;
        if (ob[11] && !(ob[9] || ob[8])) m_open = 1;
      end
      if (m_sw > 65535) m_sw = 65535;
      if (m_ab > 65535) m_ab = 65535;
      m_link = (best >= 0);
      for (int i = 0; i < NP; i++) m_streak[i] = link[i] ? ((m_streak[i] < HOLD) ? m_streak[i] + 1 : HOLD) : 0;
    end
  end

  // Every-cycle comparison against the model on the falling edge
  initial forever begin
    @(negedge clk);
    total++;
    if ({eth_link_up, active_valid, active_port, switch_count, abort_count,
         out_bus.start[0], out_bus.data_valid[0], out_bus.commit[0], out_bus.drop[0], out_bus.data[0]} !==
        {m_link, m_has, 2'(m_owner), CW'(m_sw), CW'(m_ab), m_out}) begin
      bad++;
      $display("FAIL model: got link=%0b act=%0b port=%0d sw=%0d ab=%0d bus=%03h expected link=%0b act=%0b port=%0d sw=%0d ab=%0d bus=%03h at %0t",
               eth_link_up, active_valid, active_port, switch_count, abort_count,
               {out_bus.start[0], out_bus.data_valid[0], out_bus.commit[0], out_bus.drop[0], out_bus.data[0]},
               m_link, m_has, m_owner, m_sw, m_ab, m_out, $time);
    end
  end

  task automatic clear_bus();
    in_bus.start = '0; in_bus.data_valid = '0; in_bus.commit = '0; in_bus.drop = '0; in_bus.data = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    clear_bus();
  endtask

  task automatic word(input int p, input bit st, input bit cm, input bit dr, input logic [7:0] d);
    in_bus.start[p] = st; in_bus.data_valid[p] = 1'b1; in_bus.commit[p] = cm;
    in_bus.drop[p] = dr; in_bus.data[p] = d;
  endtask

  int rem [NP];

  initial begin
    clear_bus();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {eth_link_up, active_valid, active_port, switch_count, abort_count, out_bus.start[0],
        out_bus.data_valid[0], out_bus.commit[0], out_bus.drop[0], out_bus.data[0]}, 64'd0);

    // Port 1 up at cycle 0: qualifies after hold-off, eth_link_up at cycle 17
    rst_n = 1'b1; link = 3'b010;
    repeat (16) step();
    chk("link_before_holdoff", eth_link_up, 1'b0);
    step();
    chk("link_at_17", eth_link_up, 1'b1);
    chk("port_at_17", active_port, 2'd1);
    chk("sw_at_17", switch_count, 16'd1);

    for (int k = 0; k < 5; k++) begin
      word(1, k == 0, k == 4, 0, 8'hA0 + 8'(k));
      step();
      chk("fwd_word_data", out_bus.data[0], 8'hA0 + 8'(k));
    end
    chk("fwd_commit", out_bus.commit[0], 1'b1);
    repeat (2) step();

    // Flapping port 0 never qualifies
    link[0] = 1; repeat (10) step();
    link[0] = 0; repeat (2) step();
    link[0] = 1; repeat (10) step();
    link[0] = 0; repeat (3) step();
    chk("flap_port", active_port, 2'd1);
    chk("flap_sw", switch_count, 16'd1);

    // Port 0 qualifies on word 3 of port 1 frame: no preemption, switch at gap
    link[0] = 1;
    repeat (13) step();
    for (int k = 0; k < 8; k++) begin
      word(1, k == 0, k == 7, 0, 8'hB0 + 8'(k));
      step();
    end
    chk("nopreempt_commit", {out_bus.commit[0], out_bus.data[0]}, {1'b1, 8'hB7});
    repeat (3) step();
    chk("gap_switch_port", active_port, 2'd0);
    chk("gap_switch_sw", switch_count, 16'd2);

    // Owner link drops on word 4
    for (int k = 0; k < 5; k++) begin
      if (k == 4) link[0] = 0;
      else word(0, k == 0, 0, 0, 8'hC0 + 8'(k));
      step();
    end
    chk("abort_drop", {out_bus.drop[0], out_bus.commit[0], out_bus.data_valid[0]}, 3'b100);
    chk("abort_count", abort_count, 16'd1);
    repeat (2) step();
    chk("abort_reselect_port", {active_valid, active_port}, 3'b101);
    chk("abort_reselect_sw", switch_count, 16'd3);

    // Takeover while the new owner is mid-frame: tail suppressed
    link[0] = 1;
    repeat (14) step();
    for (int k = 0; k < 8; k++) begin
      word(0, k == 0, k == 7, 0, 8'hE0 + 8'(k));
      step();
      chk("takeover_suppress", out_bus.data_valid[0], 1'b0);
    end
    chk("takeover_port", active_port, 2'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      word(0, k == 0, k == 3, 0, 8'hD0 + 8'(k));
      step();
      chk("takeover_next_frame", {out_bus.start[0], out_bus.commit[0], out_bus.data[0]},
          {k == 0, k == 3, 8'hD0 + 8'(k)});
    end

    // Reset mid-frame
    word(0, 1, 0, 0, 8'h55); step();
    word(0, 0, 0, 0, 8'h56); step();
    rst_n = 1'b0; #1;
    chk("async_reset", {eth_link_up, active_valid, active_port, switch_count, abort_count, out_bus.start[0],
        out_bus.data_valid[0], out_bus.commit[0], out_bus.drop[0], out_bus.data[0]}, 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (16) step();
    chk("holdoff_restart_low", eth_link_up, 1'b0);
    step();
    chk("holdoff_restart_high", {eth_link_up, active_port, switch_count}, {1'b1, 2'd0, 16'd1});

    // Random link flaps and traffic against the model
    for (int i = 0; i < NP; i++) rem[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (link[p]) begin if ($urandom_range(0, 149) == 0) link[p] = 0; end
        else if ($urandom_range(0, 19) == 0) link[p] = 1;
        if (rem[p] == 0) begin
          if ($urandom_range(0, 3) == 0) begin
            rem[p] = $urandom_range(1, 6);
            word(p, 1, 0, 0, 8'($urandom));
          end else begin
            in_bus.data[p] = 8'($urandom);
            in_bus.data_valid[p] = ($urandom_range(0, 7) == 0);
          end
        end else begin
          word(p, 0, 0, 0, 8'($urandom));
        end
        if (rem[p] == 1) begin
          if ($urandom_range(0, 7) == 0) in_bus.drop[p] = 1'b1;
          else in_bus.commit[p] = 1'b1;
        end
        if (rem[p] > 0) rem[p]--;
      end
      @(posedge clk); #1;
      clear_bus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
